pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Program-counter and fetch sequencer for the multi-cycle MiniRISC core.
- Sits directly downstream of the branch-decision logic and consumes its 3-bit branch_ctl word.
- Drives instruction-fetch requests, holds the architectural PC, and writes the link register for bl.
- Stops the machine on halt.

Parameters:
PC_WIDTH, 32, width of PC, fetch address, link data and rs_value
RESET_PC, 0, PC value loaded on reset
LONG_IMM_W, 26, width of long-form branch offset (b, bl, bc, bnc)
SHORT_IMM_W, 16, width of short-form branch offset (bltz, bz, bnz)
CNT_WIDTH, 16, width of taken-branch performance counter

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-high reset
fetch_ack  input  1  instruction memory has accepted/returned the word at fetch_addr
exec_done  input  1  current instruction has completed; branch_ctl, is_link, halt, imm valid this cycle
branch_ctl  input  3  {take, reg_target, short_imm} from branch decision logic
is_link  input  1  current instruction is bl
halt  input  1  current instruction is halt
rs_value  input  PC_WIDTH  register operand, target for br
imm_long  input  LONG_IMM_W  long offset field, two's complement, in instructions
imm_short  input  SHORT_IMM_W  short offset field, two's complement, in instructions
pc  output  PC_WIDTH  current instruction address (word-addressed)
fetch_req  output  1  fetch request, held until fetch_ack
fetch_addr  output  PC_WIDTH  equals pc
link_we  output  1  one-cycle pulse writing link_data to r31
link_data  output  PC_WIDTH  return address, pc+1 of the bl
halted  output  1  core stopped
taken_count  output  CNT_WIDTH  number of taken branches since reset

Behaviour:
- States: S_IDLE, S_FETCH, S_EXEC, S_HALT.
- Reset (async, immediate):
  - state=S_IDLE, pc=RESET_PC, fetch_req=0, link_we=0, link_data=0, halted=0, taken_count=0.
  - fetch_req drops in the same cycle rst rises, aborting any fetch in flight.
- S_IDLE: unconditional move to S_FETCH next cycle. The first fetch_req rises 1 cycle after reset release.
- S_FETCH:
  - fetch_req=1 and fetch_addr=pc, held stable until fetch_ack.
  - On fetch_ack, move to S_EXEC.
  - exec_done is ignored in this state.
- S_EXEC:
  - fetch_req=0; wait for exec_done.
  - fetch_ack is ignored in this state.
  - On exec_done, compute next PC and choose the next state as below.
- Next-PC selection, pc_next = pc+1 (seq):
  - halt=1: pc<=seq, move to S_HALT. branch_ctl and is_link are ignored; no link write; counter unchanged.
  - Otherwise, if take=0: pc<=seq.
  - Otherwise, if take=1 and reg_target=1: pc<=rs_value. This is br; short_imm is don't-care.
  - Otherwise, if take=1, reg_target=0, short_imm=1: pc<=seq+sext(imm_short).
  - Otherwise, if take=1, reg_target=0, short_imm=0: pc<=seq+sext(imm_long).
  - For every path except halt, next state is S_FETCH.
- Arithmetic:
  - Modulo 2^PC_WIDTH; wrap-around is silent.
  - Sign extension is to PC_WIDTH; offsets are relative to seq.
- Link:
  - When exec_done & is_link & take & !halt: link_we=1 for exactly that cycle's following edge window (registered, 1 cycle), link_data=seq.
  - is_link with take=0 produces no write.
  - link_data holds its last value otherwise.
- Counter:
  - taken_count increments by 1 on each exec_done with take=1 and halt=0.
  - Saturates at all-ones; does not wrap.
- S_HALT:
  - halted=1, fetch_req=0, pc frozen.
  - All inputs ignored; exit only via rst.
- Latency: the new pc is visible the cycle after exec_done; fetch_req for it is asserted that same cycle.
- Invalid branch_ctl encodings: take=0 with other bits set means sequential.

Test Plan:
- Reset with RESET_PC=0x100, release: pc=0x100, fetch_req=0 first cycle, 1 second cycle, fetch_addr=0x100; hold fetch_ack low 3 cycles -> fetch_req stays 1, addr stable.
- pc=0x10, exec_done, branch_ctl=100, imm_long=-3 (0x3FFFFFD) -> pc=0x0E; taken_count=1; no link_we.
- pc=0x20, branch_ctl=111, rs_value=0x400 -> pc=0x400; then branch_ctl=101, imm_short=0x0008 -> pc=0x409.
- pc=0x50, bl: is_link=1, branch_ctl=100, imm_long=0x10 -> pc=0x61, link_we pulse 1 cycle, link_data=0x51; repeat with branch_ctl=000 -> pc=0x51, no link_we.
- Wrap-around: pc=0xFFFFFFFF, branch_ctl=000 -> pc=0x0. Saturation: CNT_WIDTH=2, 5 taken branches -> taken_count=3.
- halt at pc=0x30 with branch_ctl=100 -> pc=0x31, halted=1, no further fetch_req despite fetch_ack/exec_done pulses. Then assert rst during S_FETCH -> fetch_req=0 same cycle, pc=RESET_PC.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter and fetch sequencer for the multi-cycle MiniRISC core.
// Issues fetches, resolves the next PC from branch_ctl, writes the bl link, and halts.
module pc_sequencer #(
    parameter int                      PC_WIDTH    = 32,
    parameter logic [PC_WIDTH-1:0]     RESET_PC    = '0,
    parameter int                      LONG_IMM_W  = 26,
    parameter int                      SHORT_IMM_W = 16,
    parameter int                      CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fetch_ack,
    input  logic                   exec_done,
    input  logic [2:0]             branch_ctl,
    input  logic                   is_link,
    input  logic                   halt,
    input  logic [PC_WIDTH-1:0]    rs_value,
    input  logic [LONG_IMM_W-1:0]  imm_long,
    input  logic [SHORT_IMM_W-1:0] imm_short,
    output logic [PC_WIDTH-1:0]    pc,
    output logic                   fetch_req,
    output logic [PC_WIDTH-1:0]    fetch_addr,
    output logic                   link_we,
    output logic [PC_WIDTH-1:0]    link_data,
    output logic                   halted,
    output logic [CNT_WIDTH-1:0]   taken_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_HALT
    } state_t;

    state_t state;

    logic take;
    logic reg_target;
    logic short_imm;
    assign {take, reg_target, short_imm} = branch_ctl;

    logic [PC_WIDTH-1:0] seq;
    logic [PC_WIDTH-1:0] long_off;
    logic [PC_WIDTH-1:0] short_off;
    logic [PC_WIDTH-1:0] target;

    assign seq       = pc + PC_WIDTH'(1);
    assign long_off  = {{(PC_WIDTH-LONG_IMM_W){imm_long[LONG_IMM_W-1]}}, imm_long};
    assign short_off = {{(PC_WIDTH-SHORT_IMM_W){imm_short[SHORT_IMM_W-1]}}, imm_short};
    assign fetch_addr = pc;

    // Branch target when not halting; take=0 means sequential whatever the other bits say.
    always_comb begin
        // NOTE: default assignment first so every path drives target and no latch is inferred.
        target = seq;
        if (take) begin
            if (reg_target)
                target = rs_value;
            else if (short_imm)
                target = seq + short_off;
            else
                target = seq + long_off;
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every register samples
    // pre-edge values; every register has a reset value, there is no memory to leave unreset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            fetch_req   <= 1'b0;
            link_we     <= 1'b0;
            link_data   <= '0;
            halted      <= 1'b0;
            taken_count <= '0;
        end else begin
            link_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    state     <= S_FETCH;
                    fetch_req <= 1'b1;
                end
                S_FETCH: begin
                    if (fetch_ack) begin
                        state     <= S_EXEC;
                        fetch_req <= 1'b0;
                    end
                end
                S_EXEC: begin
                    if (exec_done) begin
                        if (halt) begin
                            pc     <= seq;
                            state  <= S_HALT;
                            halted <= 1'b1;
                        end else begin
                            pc        <= target;
                            state     <= S_FETCH;
                            fetch_req <= 1'b1;
                            if (take) begin
                                if (taken_count != '1)
                                    taken_count <= taken_count + CNT_WIDTH'(1);
                                if (is_link) begin
                                    link_we   <= 1'b1;
                                    link_data <= seq;
                                end
                            end
                        end
                    end
                end
                S_HALT: begin
                    fetch_req <= 1'b0;
                    halted    <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
